// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word, RAM handshake state, arbiter FSM state
// and grant owner.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_D = 2'd1,
    GNT_I = 2'd2,
    FAULT = 2'd3
  } arb_state_t;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } grant_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Instruction/data request ports and the single RAM port behind the arbiter.
// master = CPU and RAM side (environment), slave = the arbiter itself.
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  logic      iREN;
  word_t     iaddr;
  word_t     iload;
  logic      iwait;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  word_t     dload;
  logic      dwait;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (instruction/data) arbiter onto one RAM port with alternating
// priority under contention, a grant timeout and a sticky fault state.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.slave  bus,
  output logic          err
);

  arb_state_t state;
  grant_t     last_gnt;
  logic [4:0] timer;
  logic       dreq;
  logic       gnt_req;
  logic       done;

  assign dreq = bus.dREN | bus.dWEN;

  always_comb begin
    gnt_req = 1'b0;
    case (state)
      GNT_D:   gnt_req = dreq;
      GNT_I:   gnt_req = bus.iREN;
      default: gnt_req = 1'b0;
    endcase
  end

  assign done = gnt_req && (bus.ramstate == ACCESS);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      last_gnt <= INSTR;
      timer    <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // data wins a tie only if instruction had the last grant
          if (dreq && (!bus.iREN || last_gnt == INSTR)) begin
            state    <= GNT_D;
            last_gnt <= DATA;
            timer    <= '0;
          end else if (bus.iREN) begin
            state    <= GNT_I;
            last_gnt <= INSTR;
            timer    <= '0;
          end
        end
        GNT_D, GNT_I: begin
          if (!gnt_req || done) begin
            state <= IDLE;
            timer <= '0;
          end else if (bus.ramstate == ERROR || timer == 5'(TIMEOUT - 1)) begin
            state <= FAULT;
            err   <= 1'b1;
          end else begin
            timer <= timer + 5'd1;
          end
        end
        FAULT:   state <= FAULT;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iload    = '0;
    bus.dload    = '0;
    bus.iwait    = bus.iREN;
    bus.dwait    = dreq;
    case (state)
      GNT_D: begin
        if (dreq) begin
          bus.ramaddr  = bus.daddr;
          bus.ramstore = bus.dstore;
          bus.ramWEN   = bus.dWEN;
          bus.ramREN   = bus.dREN & ~bus.dWEN;
        end
        if (done) begin
          bus.dwait = 1'b0;
          bus.dload = bus.ramload;
        end
      end
      GNT_I: begin
        if (bus.iREN) begin
          bus.ramaddr = bus.iaddr;
          bus.ramREN  = 1'b1;
        end
        if (done) begin
          bus.iwait = 1'b0;
          bus.iload = bus.ramload;
        end
      end
      FAULT: begin
        bus.iwait = 1'b1;
        bus.dwait = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level owner/age model is
// checked against the DUT every cycle, plus hand-computed literal checks.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int TO = 16;

  logic CLK = 1'b0;
  logic nRST;
  logic err;
  int   checks = 0;
  int   errors = 0;

  mem_arbiter_if bus();

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus),
    .err  (err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the RAM (0 none, 1 instr, 2 data, 3 dead), who wins the
  // next tie, and how many cycles the current owner has waited.
  int   m_own;
  bit   m_pref_d;
  int   m_age;
  logic m_dreq, m_req;

  assign m_dreq = bus.dREN | bus.dWEN;
  assign m_req  = (m_own == 1) ? bus.iREN : (m_own == 2) ? m_dreq : 1'b0;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_own    <= 0;
      m_pref_d <= 1'b1;
      m_age    <= 0;
    end else begin
      case (m_own)
        0: begin
          m_age <= 0;
          if (m_dreq && bus.iREN) begin
            m_own    <= m_pref_d ? 2 : 1;
            m_pref_d <= !m_pref_d;
          end else if (m_dreq) begin
            m_own    <= 2;
            m_pref_d <= 1'b0;
          end else if (bus.iREN) begin
            m_own    <= 1;
            m_pref_d <= 1'b1;
          end
        end
        1, 2: begin
          if (!m_req || bus.ramstate == ACCESS) m_own <= 0;
          else if (bus.ramstate == ERROR)     m_own <= 3;
          else if (m_age + 1 >= TO)           m_own <= 3;
          else                                m_age <= m_age + 1;
        end
        default: ;
      endcase
    end
  end

  always @(negedge CLK) begin
    logic        e_ren, e_wen, e_iw, e_dw, e_err;
    logic [31:0] e_addr, e_st, e_il, e_dl;
    if (nRST) begin
      e_ren = 0; e_wen = 0; e_addr = 0; e_st = 0; e_il = 0; e_dl = 0;
      e_iw = bus.iREN; e_dw = m_dreq; e_err = (m_own == 3);
      if (m_own == 1 && bus.iREN) begin
        e_ren = 1; e_addr = bus.iaddr;
        if (bus.ramstate == ACCESS) begin e_iw = 0; e_il = bus.ramload; end
      end
      if (m_own == 2 && m_dreq) begin
        e_wen = bus.dWEN; e_ren = bus.dREN & ~bus.dWEN;
        e_addr = bus.daddr; e_st = bus.dstore;
        if (bus.ramstate == ACCESS) begin e_dw = 0; e_dl = bus.ramload; end
      end
      if (m_own == 3) begin e_iw = 1; e_dw = 1; end
      chk("m_ramREN",   32'(bus.ramREN), 32'(e_ren));
      chk("m_ramWEN",   32'(bus.ramWEN), 32'(e_wen));
      chk("m_ramaddr",  bus.ramaddr,     e_addr);
      chk("m_ramstore", bus.ramstore,    e_st);
      chk("m_iwait",    32'(bus.iwait),  32'(e_iw));
      chk("m_dwait",    32'(bus.dwait),  32'(e_dw));
      chk("m_iload",    bus.iload,       e_il);
      chk("m_dload",    bus.dload,       e_dl);
      chk("m_err",      32'(err),        32'(e_err));
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in();
    bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0;
    bus.iaddr = 0; bus.daddr = 0; bus.dstore = 0;
    bus.ramload = 0; bus.ramstate = FREE;
  endtask

  task automatic do_reset();
    nRST = 0;
    step();
    step();
    nRST = 1;
  endtask

  initial begin
    int grants[$];
    idle_in();
    nRST = 0;
    #1;
    chk("rst_ramREN",  32'(bus.ramREN), 0);
    chk("rst_ramWEN",  32'(bus.ramWEN), 0);
    chk("rst_ramaddr", bus.ramaddr,     0);
    chk("rst_iload",   bus.iload,       0);
    chk("rst_err",     32'(err),        0);
    step();
    nRST = 1;
    step();

    // instruction fetch, RAM answers one cycle after grant
    bus.iREN = 1; bus.iaddr = 32'h100; bus.ramstate = BUSY;
    step();
    bus.ramstate = ACCESS; bus.ramload = 32'h8C010004;
    #1;
    chk("if_iwait",   32'(bus.iwait),  0);
    chk("if_iload",   bus.iload,       32'h8C010004);
    chk("if_ramREN",  32'(bus.ramREN), 1);
    chk("if_ramaddr", bus.ramaddr,     32'h100);
    step();
    idle_in();
    step();

    // simultaneous requests from reset: data first, bubble, then instr
    do_reset();
    bus.iREN = 1; bus.iaddr = 32'h104; bus.dREN = 1; bus.daddr = 32'h300;
    bus.ramstate = ACCESS; bus.ramload = 32'h55;
    step();
    chk("tie_first_addr", bus.ramaddr,    32'h300);
    chk("tie_first_dw",   32'(bus.dwait), 0);
    chk("tie_first_iw",   32'(bus.iwait), 1);
    step();
    chk("tie_bubble_ren", 32'(bus.ramREN), 0);
    step();
    chk("tie_second_addr", bus.ramaddr,    32'h104);
    chk("tie_second_iw",   32'(bus.iwait), 0);
    idle_in();
    step();

    // continuous iREN + dWEN: grants alternate D,I,D,I
    bus.iREN = 1; bus.iaddr = 32'h400; bus.dWEN = 1; bus.daddr = 32'h500;
    bus.dstore = 32'hDEADBEEF; bus.ramstate = ACCESS;
    for (int k = 0; k < 8; k++) begin
      step();
      if (bus.ramWEN) begin
        grants.push_back(2);
        chk("alt_ramstore", bus.ramstore, 32'hDEADBEEF);
      end else if (bus.ramREN) begin
        grants.push_back(1);
      end
    end
    chk("alt_count", grants.size(), 4);
    for (int k = 0; k < 4 && k < grants.size(); k++)
      chk("alt_order", grants[k], (k % 2 == 0) ? 2 : 1);
    idle_in();
    step();

    // read+write together: write wins
    bus.dREN = 1; bus.dWEN = 1; bus.daddr = 32'h200; bus.dstore = 32'h12345678;
    bus.ramstate = BUSY;
    step();
    chk("rw_ramWEN",  32'(bus.ramWEN), 1);
    chk("rw_ramREN",  32'(bus.ramREN), 0);
    chk("rw_ramaddr", bus.ramaddr,     32'h200);
    bus.ramstate = ACCESS;
    step();
    idle_in();
    step();

    // requester withdraws mid-grant
    bus.dREN = 1; bus.daddr = 32'h210; bus.ramstate = BUSY;
    step();
    bus.dREN = 0;
    #1;
    chk("wd_ramREN", 32'(bus.ramREN), 0);
    step();
    idle_in();
    step();

    // async reset during a write grant
    bus.dWEN = 1; bus.daddr = 32'h220; bus.dstore = 32'hA5A5A5A5; bus.ramstate = BUSY;
    step();
    chk("ar_pre_wen", 32'(bus.ramWEN), 1);
    nRST = 0;
    #1;
    chk("ar_wen", 32'(bus.ramWEN), 0);
    chk("ar_err", 32'(err),        0);
    idle_in();
    step();
    nRST = 1;
    step();
    chk("ar_post_err", 32'(err), 0);

    // timeout: BUSY held through all 16 grant cycles
    bus.iREN = 1; bus.iaddr = 32'h40; bus.ramstate = BUSY;
    for (int k = 0; k < TO; k++) step();
    chk("to_last_err", 32'(err),        0);
    chk("to_last_ren", 32'(bus.ramREN), 1);
    step();
    chk("to_err",   32'(err),           1);
    chk("to_ren",   32'(bus.ramREN),    0);
    chk("to_dwait", 32'(bus.dwait),     1);
    step();
    chk("to_sticky", 32'(err), 1);
    idle_in();
    do_reset();

    // RAM ERROR during a grant
    bus.dREN = 1; bus.daddr = 32'h80; bus.ramstate = ERROR;
    step();
    chk("er_grant_ren", 32'(bus.ramREN), 1);
    chk("er_grant_err", 32'(err),        0);
    step();
    chk("er_err",   32'(err),           1);
    chk("er_ren",   32'(bus.ramREN),    0);
    chk("er_iwait", 32'(bus.iwait),     1);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
